ahb_bridge: RTL

AHB_BRIDGE -- requirements
Module: ahb_bridge

---
 rtl/ahb_bridge_pkg.sv | 10 +
 rtl/ahb_bridge_decode.sv | 40 ++++
 rtl/ahb_bridge.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ahb_bridge_pkg.sv
// ahb_bridge_pkg: shared FSM/region types and CTRL register map for the AHB bridge.
package ahb_bridge_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_RSP} state_t;
  typedef enum logic [2:0] {R_IM, R_DM, R_RF, R_CTRL, R_NONE} region_t;
  localparam logic [3:0] OFF_ID = 4'h0;
  localparam logic [3:0] OFF_RSTN = 4'h4;
  localparam logic [3:0] OFF_CYCLES = 4'h8;
  localparam logic [3:0] OFF_RSVD = 4'hC;
  localparam logic [31:0] CTRL_ID = 32'hB21D_0002;
endpackage

// File: rtl/ahb_bridge_decode.sv
// ahb_bridge_decode: byte address -> region select and word index within that region.
module ahb_bridge_decode import ahb_bridge_pkg::*; #(
  parameter int MEM_AW = 11,
  parameter int RF_AW = 5,
  parameter int IDX_W = 11,
  parameter logic [31:0] IM_BASE = 32'h4000_0000,
  parameter logic [31:0] DM_BASE = 32'h4000_2000,
  parameter logic [31:0] RF_BASE = 32'h4000_4000,
  parameter logic [31:0] CTRL_BASE = 32'h4000_8000
) (
  input  logic [31:0]      i_addr,
  output region_t          o_region,
  output logic [IDX_W-1:0] o_idx
);
  localparam logic [31:0] MEM_SZ = 32'd4 << MEM_AW;
  localparam logic [31:0] RF_SZ = 32'd4 << RF_AW;
  logic [31:0] w_im_off, w_dm_off, w_rf_off, w_ctrl_off;
  assign w_im_off = i_addr - IM_BASE;
  assign w_dm_off = i_addr - DM_BASE;
  assign w_rf_off = i_addr - RF_BASE;
  assign w_ctrl_off = i_addr - CTRL_BASE;
  // Addresses below a base wrap to huge offsets, so one unsigned compare bounds both ends.
  always_comb begin
    o_region = R_NONE;
    o_idx = '0;
    if (w_im_off < MEM_SZ) begin
      o_region = R_IM;
      o_idx = IDX_W'(w_im_off >> 2);
    end else if (w_dm_off < MEM_SZ) begin
      o_region = R_DM;
      o_idx = IDX_W'(w_dm_off >> 2);
    end else if (w_rf_off < RF_SZ) begin
      o_region = R_RF;
      o_idx = IDX_W'(w_rf_off >> 2);
    end else if (w_ctrl_off < 32'd16) begin
      o_region = R_CTRL;
      o_idx = IDX_W'(w_ctrl_off >> 2);
    end
  end
endmodule

// File: rtl/ahb_bridge.sv
// ahb_bridge: single-outstanding AHB-style slave fronting IM/DM/RF and a CTRL block.
// Define AHB_BRIDGE_ERR_RESP_EN to answer unmapped accesses with ahb_resp=1.
module ahb_bridge import ahb_bridge_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int MEM_AW = 11,
  parameter int RF_AW = 5,
  parameter logic [31:0] IM_BASE = 32'h4000_0000,
  parameter logic [31:0] DM_BASE = 32'h4000_2000,
  parameter logic [31:0] RF_BASE = 32'h4000_4000,
  parameter logic [31:0] CTRL_BASE = 32'h4000_8000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ahb_valid,
  input  logic              ahb_we,
  input  logic [31:0]       ahb_addr,
  input  logic [DATA_W-1:0] ahb_write_data,
  output logic              ahb_ready,
  output logic              ahb_resp,
  output logic [DATA_W-1:0] ahb_read_data,
  output logic              cpu_rstn,
  output logic [RF_AW-1:0]  ahb_rf_addr,
  input  logic [DATA_W-1:0] ahb_rf_data,
  output logic [MEM_AW-1:0] ahb_im_addr,
  output logic [DATA_W-1:0] ahb_im_din,
  output logic              ahb_im_wen,
  input  logic [DATA_W-1:0] ahb_im_dout,
  output logic [MEM_AW-1:0] ahb_dm_addr,
  output logic [DATA_W-1:0] ahb_dm_din,
  output logic              ahb_dm_wen,
  input  logic [DATA_W-1:0] ahb_dm_dout
);
  localparam int IDX_W = MEM_AW > RF_AW ? MEM_AW : RF_AW;
  state_t r_state, w_next;
  region_t w_region, r_region;
  logic [IDX_W-1:0] w_idx;
  logic [1:0] r_ctrl_idx;
  logic r_we, r_cpu_rstn, w_start, w_acc, w_ctrl_wr;
  logic [DATA_W-1:0] r_wdata, r_rdata, w_ctrl_rd;
  logic [31:0] r_cycles;
  logic [3:0] w_ctrl_off;
  logic [MEM_AW-1:0] r_im_addr, r_dm_addr;
  logic [RF_AW-1:0] r_rf_addr;

  ahb_bridge_decode #(
    .MEM_AW(MEM_AW), .RF_AW(RF_AW), .IDX_W(IDX_W),
    .IM_BASE(IM_BASE), .DM_BASE(DM_BASE), .RF_BASE(RF_BASE), .CTRL_BASE(CTRL_BASE)
  ) u_decode (
    .i_addr(ahb_addr),
    .o_region(w_region),
    .o_idx(w_idx)
  );

  assign w_start = r_state == S_IDLE && ahb_valid;
  assign w_acc = r_state == S_ACC;
  assign w_ctrl_off = {r_ctrl_idx, 2'b00};
  assign w_ctrl_wr = w_acc && r_we && r_region == R_CTRL;

  always_ff @(posedge clk)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    w_next = w_start ? (w_region == R_NONE ? S_RSP : S_ACC) :
             w_acc ? S_RSP :
             r_state == S_RSP ? S_IDLE : r_state;
  end

  always_comb begin
    w_ctrl_rd = '0;
    w_ctrl_rd = w_ctrl_off == OFF_ID ? DATA_W'(CTRL_ID) :
                w_ctrl_off == OFF_RSTN ? DATA_W'(r_cpu_rstn) :
                w_ctrl_off == OFF_CYCLES ? DATA_W'(r_cycles) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we <= 1'b0;
      r_region <= R_NONE;
      r_ctrl_idx <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_im_addr <= '0;
      r_dm_addr <= '0;
      r_rf_addr <= '0;
      r_cpu_rstn <= 1'b0;
      r_cycles <= '0;
    end else begin
      if (w_start) begin
        r_we <= ahb_we;
        r_region <= w_region;
        r_ctrl_idx <= w_idx[1:0];
        r_wdata <= ahb_write_data;
        if (w_region == R_IM) r_im_addr <= w_idx[MEM_AW-1:0];
        if (w_region == R_DM) r_dm_addr <= w_idx[MEM_AW-1:0];
        if (w_region == R_RF) r_rf_addr <= w_idx[RF_AW-1:0];
        if (w_region == R_NONE && !ahb_we) r_rdata <= '0;
      end
      if (w_acc && !r_we)
        r_rdata <= r_region == R_IM ? ahb_im_dout :
                   r_region == R_DM ? ahb_dm_dout :
                   r_region == R_RF ? ahb_rf_data : w_ctrl_rd;
      if (w_ctrl_wr && w_ctrl_off == OFF_RSTN) r_cpu_rstn <= r_wdata[0];
      // A clear lands on the same edge as an increment and must take priority.
      r_cycles <= (w_ctrl_wr && w_ctrl_off == OFF_CYCLES) ? '0 : r_cycles + {31'b0, r_cpu_rstn};
    end
  end

`ifdef AHB_BRIDGE_ERR_RESP_EN
  logic r_resp;
  always_ff @(posedge clk)
    if (rst) r_resp <= 1'b0;
    else if (w_start) r_resp <= w_region == R_NONE;
  assign ahb_resp = r_resp;
`else
  assign ahb_resp = 1'b0;
`endif

  assign ahb_ready = r_state == S_RSP;
  assign ahb_read_data = r_rdata;
  assign cpu_rstn = r_cpu_rstn;
  assign ahb_im_addr = r_im_addr;
  assign ahb_dm_addr = r_dm_addr;
  assign ahb_rf_addr = r_rf_addr;
  assign ahb_im_din = r_wdata;
  assign ahb_dm_din = r_wdata;
  // Gated by rst so a write caught mid-transfer never reaches memory on the reset edge.
  assign ahb_im_wen = w_acc && r_we && r_region == R_IM && !rst;
  assign ahb_dm_wen = w_acc && r_we && r_region == R_DM && !rst;
endmodule
